// File: rtl/d_flip_flop_if.sv
// rtl/d_flip_flop_if.sv - data/output bundle for the d_flip_flop storage cell
//
// Signals:
//   d     WIDTH  data presented to the cell, captured on the rising clk edge
//   q     WIDTH  stored value
//   qbar  WIDTH  bitwise complement of q
// Modports:
//   master  drives d, observes q/qbar (the user of the cell)
//   slave   observes d, drives q/qbar (the cell itself)
`timescale 1ns/1ps

interface d_flip_flop_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (
    output d,
    input  q,
    input  qbar
  );

  modport slave (
    input  d,
    output q,
    output qbar
  );
endinterface

// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - rising-edge D flip-flop bank with complementary outputs and async active-low clear
//
// Parameters:
//   WIDTH        number of independent bits stored
//   RESET_VALUE  value forced onto q while clr is low (qbar gets its complement)
// Ports:
//   clk        input   rising-edge sampling clock
//   clr        input   asynchronous clear, active low
//   bus.d      input   WIDTH data captured on the rising clk edge
//   bus.q      output  WIDTH stored value
//   bus.qbar   output  WIDTH bitwise complement of q
`timescale 1ns/1ps

module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic          clk,
  input  logic          clr,
  d_flip_flop_if.slave  bus
);

  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] state_q;

  // Each bit is its own flip-flop; they only share clk and clr.
  always_comb begin
    state_d = bus.d;
  end

  // Clear sits in the sensitivity list so it acts without a clock edge and
  // wins over a coincident rising edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RESET_VALUE;
    end else begin
      state_q <= state_d;
    end
  end

  // qbar is derived from the same state element so it can never disagree
  // with q, not even for a single simulation step.
  assign bus.q    = state_q;
  assign bus.qbar = ~state_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - self-checking bench for d_flip_flop (1-bit cell and 8-bit bank)
`timescale 1ns/1ps

module tb_d_flip_flop;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       clr;
  logic       d1;
  logic [7:0] d8;
  logic       toggle;

  logic       e1;
  logic [7:0] e8;

  int checks;
  int failures;

  d_flip_flop_if #(.WIDTH(1)) if1 ();
  d_flip_flop_if #(.WIDTH(8)) if8 ();

  assign if1.d = toggle ? if1.qbar : d1;
  assign if8.d = toggle ? if8.qbar : d8;

  d_flip_flop #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .clr (clr),
    .bus (if1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .clk (clk),
    .clr (clr),
    .bus (if8)
  );

  initial begin
    clk = 1'b1;
    forever #1 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic       n1;
    logic [7:0] n8;
    n1 = ~e1;
    n8 = ~e8;
    chk({tag, ".q1"},    {7'b0, if1.q},    {7'b0, e1});
    chk({tag, ".qbar1"}, {7'b0, if1.qbar}, {7'b0, n1});
    chk({tag, ".q8"},    if8.q,            e8);
    chk({tag, ".qbar8"}, if8.qbar,         n8);
  endtask

  task automatic model_capture();
    if (clr) begin
      e1 = d1;
      e8 = d8;
    end else begin
      e1 = 1'b0;
      e8 = RV8;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b0;
    d1       = 1'b0;
    d8       = 8'($urandom);
    toggle   = 1'b0;
    e1       = 1'b0;
    e8       = RV8;

    // Clear held from time zero: clk edges at 2 and 4 ns must be ignored.
    repeat (9) begin
      #0.5;
      chk_all("clear_hold");
    end

    // Release at 5 ns (clk falling), no change until the next rising edge.
    #0.5;
    clr = 1'b1;
    d1  = 1'b1;
    d8  = 8'($urandom);
    #0.5;
    chk_all("release_nochange");
    @(posedge clk);
    model_capture();
    #0.5;
    chk_all("capture_one");

    @(negedge clk);
    d1 = 1'b0;
    d8 = 8'($urandom);
    #0.5;
    chk_all("hold_between_edges");
    @(posedge clk);
    model_capture();
    #0.5;
    chk_all("capture_zero");

    // d glitch entirely inside the clk-high phase.
    #0.1;
    d1 = 1'b1;
    d8 = ~d8;
    #0.2;
    d1 = 1'b0;
    d8 = ~d8;
    @(negedge clk);
    #0.1;
    chk_all("glitch_fall");
    @(posedge clk);
    model_capture();
    #0.5;
    chk_all("glitch_rise");

    // Load a one, then clear asynchronously between edges.
    d1 = 1'b1;
    d8 = 8'($urandom);
    @(posedge clk);
    model_capture();
    #0.5;
    chk_all("pre_clear");
    #1.0;
    clr = 1'b0;
    e1  = 1'b0;
    e8  = RV8;
    #0.1;
    chk_all("async_clear");
    #0.9;
    clr = 1'b1;
    #0.3;
    chk_all("release_hold");

    // Clear falling at the same instant as a rising edge with d = 1.
    @(posedge clk);
    clr = 1'b0;
    e1  = 1'b0;
    e8  = RV8;
    #0.5;
    chk_all("clear_priority");
    #0.5;
    clr = 1'b1;
    @(posedge clk);
    model_capture();
    #0.5;
    chk_all("after_priority");

    // Toggle mode: d follows qbar, q divides the clock by two.
    #0.5;
    clr    = 1'b0;
    toggle = 1'b1;
    e1     = 1'b0;
    e8     = RV8;
    #0.2;
    chk_all("toggle_clear");
    #0.3;
    clr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #0.5;
      e1 = 1'(k % 2);
      e8 = (k % 2 == 1) ? ~RV8 : RV8;
      chk_all("toggle");
    end
    #0.2;
    toggle = 1'b0;

    // Randomised operation with occasional asynchronous clears.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #0.2;
      d1 = 1'($urandom_range(0, 1));
      d8 = 8'($urandom);
      if (clr && $urandom_range(0, 5) == 0) begin
        #0.2;
        clr = 1'b0;
        e1  = 1'b0;
        e8  = RV8;
        #0.1;
        chk_all("rnd_async_clear");
      end else if (!clr && $urandom_range(0, 1) == 0) begin
        #0.2;
        clr = 1'b1;
        #0.1;
        chk_all("rnd_release");
      end
      @(posedge clk);
      model_capture();
      #0.3;
      chk_all("rnd_capture");
      #0.2;
      d1 = 1'($urandom_range(0, 1));
      d8 = 8'($urandom);
      #0.1;
      chk_all("rnd_hold");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
